tmr_bank: RTL and testbench
===========================

// Module: tmr_bank
// PURPOSE
// - Parametrised bank of NCH independent down-counting timers for the mips789 SoC peripheral bus.
// - Successor to the single-channel timer: per-channel one-shot/auto-reload mode, enable, irq mask,
//   W1C sticky status, registered readback and an aggregated interrupt to the CP0 irq input.
// - Sits on the data-memory-mapped device bus next to the 7-seg/uart devices.
// PARAMETERS
// - NCH    4   number of timer channels (1..8)
// - W      32  counter/reload width in bits (8..32)
// - PSW    8   prescaler width (used only with MIPS789_TMR_PRESCALE_EN)
// PORTS
// - clk      in   1               system clock, all logic posedge
// - rst_n    in   1               asynchronous, active-low reset
// - wr_en    in   1               register write strobe, one clk
// - rd_en    in   1               register read strobe, one clk
// - addr     in   $clog2(NCH)+2   {channel, reg[1:0]}; reg 0=RELOAD 1=COUNT 2=CTRL 3=STATUS
// - wdata    in   W               write data
// - rdata    out  W               read data, valid the cycle after rd_en
// - ch_irq   out  NCH             per-channel masked interrupt (flag & irq_en)
// - irq      out  1               OR of ch_irq, level, to CP0
// BEHAVIOUR
// - Reset: all RELOAD/COUNT=0, CTRL=0 (disabled), flags=0, rdata=0, ch_irq=0, irq=0.
// - CTRL bits: [0] en, [1] mode (0 one-shot, 1 auto-reload), [2] irq_en; upper bits read 0.
// - Write RELOAD: RELOAD<=wdata and COUNT<=wdata in same cycle (load); flag unaffected.
// - Write COUNT: ignored (read-only). Write STATUS: bit0=1 clears flag (W1C); 0 no effect.
// - Tick: every clk when no prescaler (see CONFIGURATION). Count on tick only when en=1.
// - en=1, tick, COUNT!=0: COUNT<=COUNT-1.
// - en=1, tick, COUNT==0 (expiry): flag<=1; auto-reload: COUNT<=RELOAD; one-shot: en<=0, COUNT stays 0.
// - Period in auto-reload = RELOAD+1 ticks; RELOAD=0 with auto-reload expires every tick.
// - Enabling with COUNT==0 expires on first tick (flag set one tick after en write).
// - Simultaneous RELOAD write and expiry: load wins for COUNT; flag still set.
// - Simultaneous W1C and expiry on same channel: set wins, flag stays 1 (no lost event).
// - Simultaneous CTRL write and one-shot expiry: CTRL write value wins for en.
// - Width: all arithmetic modulo 2^W; no underflow past 0 (expiry handles 0).
// - Readback: rdata registered, 1-cycle latency, holds last value when rd_en=0; unused reg bits 0.
// - ch_irq/irq combinational from registered flag & irq_en, so irq asserts 1 clk after expiry edge.
// - Out-of-range channel index (NCH not power of 2): writes ignored, reads return 0.
// - rst_n asserted mid-count: everything returns to reset values immediately, asynchronously.
// CONFIGURATION
// - MIPS789_TMR_PRESCALE_EN defined: shared PSW-bit prescaler register at channel 0 reg 1
//   (COUNT addr becomes write-only PRESCALE on write, reads still COUNT); free-running divider
//   emits tick when divider==PRESCALE then restarts at 0; PRESCALE=0 gives tick every clk;
//   writing PRESCALE restarts divider. Reset PRESCALE=0.
// - Not defined: no prescaler logic, tick=1 every clk, writes to COUNT fully ignored.
// STRUCTURE
// - Register offsets, CTRL bit positions and STATUS bit go in mips789_defs.v as `define constants
//   (TMR_REG_RELOAD/COUNT/CTRL/STATUS, TMR_CTRL_EN/MODE/IRQEN).
// - Sub-module tmr_bank_ch: one channel (RELOAD, COUNT, CTRL, flag, expiry logic), instanced
//   NCH times via generate; top holds address decode, prescaler, read mux, irq OR.
// TESTING
// - Reset: assert rst_n=0 mid-count -> all reads 0, irq=0 next cycle after release.
// - Auto-reload ch0: RELOAD=3, CTRL=7 -> flag/irq every 4 clks; COUNT reads 3,2,1,0,3...
// - One-shot ch1: RELOAD=5, CTRL=5 -> irq after 6 ticks, CTRL.en reads 0, COUNT stays 0.
// - W1C race: STATUS write 1 on exact expiry clk -> flag remains 1; clear next cycle -> irq=0.
// - Mask/aggregate: ch2 irq_en=0 expiring, ch3 irq_en=1 expiring -> ch_irq=4'b1000, irq=1.
// - With MIPS789_TMR_PRESCALE_EN: PRESCALE=2, RELOAD=1 auto -> expiry every 6 clks.

Source files
------------

// File: rtl/tmr_bank_pkg.sv
// Shared types and constants for the tmr_bank timer peripheral.
// Register map per channel: {channel, reg[1:0]} with reg 0=RELOAD 1=COUNT 2=CTRL 3=STATUS.
package tmr_bank_pkg;

  typedef enum logic [1:0] {
    REG_RELOAD = 2'd0,
    REG_COUNT  = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } tmr_reg_e;

  // CTRL layout: bit 0 en, bit 1 mode (1 = auto-reload), bit 2 irq_en.
  typedef struct packed {
    logic irq_en;
    logic mode;
    logic en;
  } tmr_ctrl_t;

  localparam int CTRL_W      = 3;
  localparam int STATUS_FLAG = 0;

endpackage

// File: rtl/tmr_bank_ch.sv
// One timer channel: RELOAD, COUNT, CTRL and the sticky expiry flag.
// Priorities on a shared edge: RELOAD write beats expiry for COUNT, CTRL write beats the
// one-shot auto-disable for en, and expiry beats W1C for the flag so no event is lost.
module tmr_bank_ch
  import tmr_bank_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         wr_reload,
  input  logic         wr_ctrl,
  input  logic         wr_status,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] reload,
  output logic [W-1:0] count,
  output tmr_ctrl_t    ctrl,
  output logic         flag
);

  logic [W-1:0] reload_q, reload_d;
  logic [W-1:0] count_q, count_d;
  tmr_ctrl_t    ctrl_q, ctrl_d;
  logic         flag_q, flag_d;
  logic         expire;

  // Next-state: count/expiry first, then register writes layered on top by priority.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a missed path would infer a latch.
    reload_d = reload_q;
    count_d  = count_q;
    ctrl_d   = ctrl_q;
    flag_d   = flag_q;
    expire   = ctrl_q.en && tick && (count_q == '0);

    if (ctrl_q.en && tick) begin
      if (!expire) begin
        count_d = count_q - W'(1);
      end else if (ctrl_q.mode) begin
        count_d = reload_q;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end

    if (wr_status && wdata[STATUS_FLAG]) flag_d = 1'b0;
    if (expire) flag_d = 1'b1;

    if (wr_ctrl) ctrl_d = tmr_ctrl_t'(wdata[CTRL_W-1:0]);

    if (wr_reload) begin
      reload_d = wdata;
      count_d  = wdata;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would race.
    if (!rst_n) begin
      reload_q <= '0;
      count_q  <= '0;
      ctrl_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      ctrl_q   <= ctrl_d;
      flag_q   <= flag_d;
    end
  end

  assign reload = reload_q;
  assign count  = count_q;
  assign ctrl   = ctrl_q;
  assign flag   = flag_q;

endmodule

// File: rtl/tmr_bank.sv
// Bank of NCH down-counting timers on the mips789 device bus.
// Top level: address decode, optional shared prescaler, registered read mux, irq aggregation.
// Optional feature: define MIPS789_TMR_PRESCALE_EN for the shared PSW-bit prescaler written
// at channel 0 reg 1 (reads of that address still return channel 0 COUNT).
module tmr_bank
  import tmr_bank_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 32,
  parameter int PSW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [$clog2(NCH)+1:0] addr,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [NCH-1:0]         ch_irq,
  output logic                   irq
);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("tmr_bank: NCH must be in 1..8");
  end
  if (PSW < 1 || PSW > W) begin : g_bad_psw
    $error("tmr_bank: PSW must be in 1..W");
  end

  int unsigned  ch_sel;
  tmr_reg_e     reg_sel;
  logic         tick;

  logic [W-1:0] reload_a [NCH];
  logic [W-1:0] count_a  [NCH];
  tmr_ctrl_t    ctrl_a   [NCH];
  logic [NCH-1:0] flag_a;

  logic [W-1:0] rdata_q, rdata_d;

  // Channel index may exceed NCH-1 when NCH is not a power of two; such accesses hit nothing.
  assign ch_sel  = 32'(addr) >> 2;
  assign reg_sel = tmr_reg_e'(addr[1:0]);

`ifdef MIPS789_TMR_PRESCALE_EN
  logic [PSW-1:0] prescale_q, prescale_d;
  logic [PSW-1:0] div_q, div_d;
  logic           wr_prescale;

  assign wr_prescale = wr_en && (ch_sel == 0) && (reg_sel == REG_COUNT);
  assign tick        = (div_q == prescale_q);

  // Free-running divider; a PRESCALE write restarts it from 0.
  always_comb begin
    prescale_d = prescale_q;
    div_d      = tick ? '0 : div_q + PSW'(1);
    if (wr_prescale) begin
      prescale_d = wdata[PSW-1:0];
      div_d      = '0;
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      div_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      div_q      <= div_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit = wr_en && (ch_sel == i);

    tmr_bank_ch #(.W(W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .wr_reload (hit && (reg_sel == REG_RELOAD)),
      .wr_ctrl   (hit && (reg_sel == REG_CTRL)),
      .wr_status (hit && (reg_sel == REG_STATUS)),
      .wdata     (wdata),
      .reload    (reload_a[i]),
      .count     (count_a[i]),
      .ctrl      (ctrl_a[i]),
      .flag      (flag_a[i])
    );

    assign ch_irq[i] = flag_a[i] & ctrl_a[i].irq_en;
  end

  assign irq = |ch_irq;

  // Read mux: sample on rd_en, otherwise hold; out-of-range channels read as 0.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      for (int i = 0; i < NCH; i++) begin
        if (ch_sel == unsigned'(i)) begin
          case (reg_sel)
            REG_RELOAD: rdata_d = reload_a[i];
            REG_COUNT:  rdata_d = count_a[i];
            REG_CTRL:   rdata_d = W'(ctrl_a[i]);
            REG_STATUS: rdata_d = W'(flag_a[i]);
            default:    rdata_d = '0;
          endcase
        end
      end
    end
  end

  // Registered readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_tmr_bank.sv
// Self-checking bench for tmr_bank: directed scenarios followed by random bus traffic.
// Reads push the expected value into a scoreboard queue; a negedge monitor pops and compares
// rdata and also checks ch_irq/irq every cycle against a behavioural model of the timers.
module tb_tmr_bank;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int PSW = 8;
  localparam int AW  = $clog2(NCH) + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic           rd_en = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [W-1:0]   wdata = '0;
  logic [W-1:0]   rdata;
  logic [NCH-1:0] ch_irq;
  logic           irq;

  always #5 clk = ~clk;

  tmr_bank #(.NCH(NCH), .W(W), .PSW(PSW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ch_irq (ch_irq),
    .irq    (irq)
  );

  // Behavioural model state.
  logic [W-1:0]   m_reload [NCH];
  logic [W-1:0]   m_count  [NCH];
  bit             m_en     [NCH];
  bit             m_mode   [NCH];
  bit             m_ie     [NCH];
  bit             m_flag   [NCH];
  logic [PSW-1:0] m_presc;
  logic [PSW-1:0] m_div;

  logic [W-1:0] exp_q[$];
  bit           rd_pend = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_reload[c] = '0; m_count[c] = '0;
      m_en[c] = 0; m_mode[c] = 0; m_ie[c] = 0; m_flag[c] = 0;
    end
    m_presc = '0;
    m_div   = '0;
  endtask

  function automatic logic [W-1:0] model_read(input int a);
    int c = a / 4;
    if (c >= NCH) return '0;
    case (a % 4)
      0:       return m_reload[c];
      1:       return m_count[c];
      2:       return W'({m_ie[c], m_mode[c], m_en[c]});
      default: return W'(m_flag[c]);
    endcase
  endfunction

  function automatic logic [NCH-1:0] model_irq();
    logic [NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c] = m_flag[c] & m_ie[c];
    return v;
  endfunction

  // One clock edge of the timer bank, following the written behavioural rules.
  task automatic model_edge(input bit w, input int a, input logic [W-1:0] d);
    bit tk;
    bit expd [NCH];
    int c;
`ifdef MIPS789_TMR_PRESCALE_EN
    tk    = (m_div == m_presc);
    m_div = tk ? '0 : m_div + 1'b1;
`else
    tk = 1'b1;
`endif
    for (int k = 0; k < NCH; k++) begin
      expd[k] = 0;
      if (m_en[k] && tk) begin
        if (m_count[k] == 0) begin
          expd[k]   = 1;
          m_flag[k] = 1;
          if (m_mode[k]) m_count[k] = m_reload[k];
          else           m_en[k] = 0;
        end else begin
          m_count[k] = m_count[k] - 1;
        end
      end
    end
    c = a / 4;
    if (w && c < NCH) begin
      case (a % 4)
        0: begin m_reload[c] = d; m_count[c] = d; end
        1: begin
`ifdef MIPS789_TMR_PRESCALE_EN
          if (c == 0) begin m_presc = d[PSW-1:0]; m_div = '0; end
`endif
        end
        2: begin m_en[c] = d[0]; m_mode[c] = d[1]; m_ie[c] = d[2]; end
        default: if (d[0] && !expd[c]) m_flag[c] = 0;
      endcase
    end
  endtask

  // One bus cycle: present inputs, let the edge happen, advance the model.
  task automatic drive(input bit w, input bit r, input int a, input logic [W-1:0] d);
    wr_en = w; rd_en = r; addr = AW'(a); wdata = d;
    if (r) exp_q.push_back(model_read(a));
    @(posedge clk);
    model_edge(w, a, d);
    rd_pend = r;
    #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0);
  endtask

  task automatic read_all();
    for (int a = 0; a < NCH * 4; a++) drive(0, 1, a, '0);
  endtask

  // Monitor: scoreboard pop for reads, irq outputs checked every cycle.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) check("rd_queue_empty", 32'd1, 32'd0);
      else                   check("rdata", rdata, exp_q.pop_front());
    end
    check("ch_irq", 32'(ch_irq), 32'(model_irq()));
    check("irq", 32'(irq), 32'(|model_irq()));
  end

  initial begin
    int a;
    int r;
    logic [W-1:0] d;
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    read_all();

`ifdef MIPS789_TMR_PRESCALE_EN
    // Prescaler: PRESCALE=2, RELOAD=1 auto-reload -> expiry every 6 clocks.
    drive(1, 0, 1, 2);
    drive(1, 0, 0, 1);
    drive(1, 0, 2, 7);
    for (int i = 0; i < 24; i++) drive(0, 1, (i % 2) ? 3 : 1, '0);
    drive(1, 0, 2, 0);
    drive(1, 0, 3, 1);
    drive(1, 0, 1, 0);
`endif

    // Auto-reload ch0: RELOAD=3, CTRL=7, COUNT reads cycle 3,2,1,0.
    drive(1, 0, 0, 3);
    drive(1, 0, 2, 7);
    for (int i = 0; i < 10; i++) drive(0, 1, 1, '0);

    // One-shot ch1: RELOAD=5, CTRL=5.
    drive(1, 0, 4, 5);
    drive(1, 0, 6, 5);
    for (int i = 0; i < 8; i++) drive(0, 1, 5, '0);
    drive(0, 1, 6, '0);
    check("oneshot_ctrl", rdata, 32'd4);
    drive(0, 1, 5, '0);
    check("oneshot_count", rdata, 32'd0);
    check("oneshot_irq", 32'(ch_irq[1]), 32'd1);
    drive(1, 0, 7, 1);

    // W1C race on ch0: clear on the exact expiry edge, flag must survive.
    for (int i = 0; i < 8 && m_count[0] != 0; i++) idle(1);
    drive(1, 0, 3, 1);
    drive(0, 1, 3, '0);
    check("w1c_race_flag", rdata, 32'd1);
    drive(1, 0, 3, 1);
    check("w1c_clear_irq", 32'(irq), 32'd0);

    // Mask/aggregate: ch2 masked, ch3 unmasked, both expiring every tick.
    drive(1, 0, 2, 0);
    drive(1, 0, 8, 0);
    drive(1, 0, 10, 3);
    drive(1, 0, 12, 0);
    drive(1, 0, 14, 7);
    idle(2);
    check("mask_ch_irq", 32'(ch_irq), 32'h8);
    check("mask_irq", 32'(irq), 32'd1);

    // Asynchronous reset mid-count.
    drive(1, 0, 4, 9);
    drive(1, 0, 6, 3);
    drive(0, 1, 13, '0);
    rst_n = 0;
    model_reset();
    rd_pend = 0;
    exp_q.delete();
    #2;
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_ch_irq", 32'(ch_irq), 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    #1 rst_n = 1;
    idle(1);
    check("post_rst_irq", 32'(irq), 32'd0);
    read_all();

    // Random traffic with small reload values so expiries and races occur often.
    for (int i = 0; i < 1500; i++) begin
      a = int'($urandom_range(0, NCH * 4 - 1));
      r = int'($urandom_range(0, 9));
      case (a % 4)
        0:       d = W'($urandom_range(0, 6));
        1:       d = W'($urandom_range(0, 3));
        2:       d = W'($urandom_range(0, 7));
        default: d = W'($urandom_range(0, 1));
      endcase
      if (r < 3) drive(1, ($urandom_range(0, 1) == 1), a, d);
      else       drive(0, ($urandom_range(0, 1) == 1), int'($urandom_range(0, NCH * 4 - 1)), '0);
    end

    idle(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
